// File: rtl/alu_cw_pkg.sv
// Shared widths, packed control-word layout and field offsets for the ALU control-word queue.
// Offsets count up from the LSB; the word is packed MSB-first in field order.
package alu_cw_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_OP_WIDTH   = 4;
    localparam int unsigned DEF_SEL_WIDTH  = 4;
    localparam int unsigned LOAD_SRC_WIDTH = 2;

    function automatic int unsigned cw_width(input int unsigned data_w,
                                             input int unsigned op_w,
                                             input int unsigned sel_w);
        return 1 + op_w + 2 * data_w + 3 * sel_w + 2 + 2 + 2;
    endfunction

    // Fields below out_select have fixed widths, so their offsets are constant.
    localparam int unsigned OFF_STORE_TO_STK = 0;
    localparam int unsigned OFF_STORE_TO_MEM = 1;
    localparam int unsigned OFF_LOAD_SRC     = 2;
    localparam int unsigned OFF_OUT_SELECT   = 4;

    function automatic int unsigned off_b_source(input int unsigned sel_w);
        return OFF_OUT_SELECT + sel_w;
    endfunction

    function automatic int unsigned off_a_source(input int unsigned sel_w);
        return off_b_source(sel_w) + 1;
    endfunction

    function automatic int unsigned off_b_select(input int unsigned sel_w);
        return off_a_source(sel_w) + 1;
    endfunction

    function automatic int unsigned off_a_select(input int unsigned sel_w);
        return off_b_select(sel_w) + sel_w;
    endfunction

    function automatic int unsigned off_b_altern(input int unsigned sel_w);
        return off_a_select(sel_w) + sel_w;
    endfunction

    function automatic int unsigned off_a_altern(input int unsigned data_w,
                                                 input int unsigned sel_w);
        return off_b_altern(sel_w) + data_w;
    endfunction

    function automatic int unsigned off_op(input int unsigned data_w,
                                           input int unsigned sel_w);
        return off_a_altern(data_w, sel_w) + data_w;
    endfunction

    function automatic int unsigned off_pc_inc(input int unsigned data_w,
                                               input int unsigned op_w,
                                               input int unsigned sel_w);
        return off_op(data_w, sel_w) + op_w;
    endfunction

    localparam int unsigned DEF_CW_WIDTH     = cw_width(DEF_DATA_WIDTH, DEF_OP_WIDTH, DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_B_SOURCE = off_b_source(DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_A_SOURCE = off_a_source(DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_B_SELECT = off_b_select(DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_A_SELECT = off_a_select(DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_B_ALTERN = off_b_altern(DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_A_ALTERN = off_a_altern(DEF_DATA_WIDTH, DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_OP       = off_op(DEF_DATA_WIDTH, DEF_SEL_WIDTH);
    localparam int unsigned DEF_OFF_PC_INC   = off_pc_inc(DEF_DATA_WIDTH, DEF_OP_WIDTH, DEF_SEL_WIDTH);

    typedef struct packed {
        logic                      pc_inc;
        logic [DEF_OP_WIDTH-1:0]   op;
        logic [DEF_DATA_WIDTH-1:0] a_altern;
        logic [DEF_DATA_WIDTH-1:0] b_altern;
        logic [DEF_SEL_WIDTH-1:0]  a_select;
        logic [DEF_SEL_WIDTH-1:0]  b_select;
        logic                      a_source;
        logic                      b_source;
        logic [DEF_SEL_WIDTH-1:0]  out_select;
        logic [LOAD_SRC_WIDTH-1:0] load_src;
        logic                      store_to_mem;
        logic                      store_to_stk;
    } alu_cw_t;

endpackage

// File: rtl/alu_cw_field_split.sv
// Combinational split of one packed control word into ALU datapath fields.
// Every field is forced to zero when the word is not valid, so strobes cannot fire while idle.
module alu_cw_field_split
    import alu_cw_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned OP_WIDTH   = DEF_OP_WIDTH,
    parameter  int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
    localparam int unsigned CW_WIDTH   = cw_width(DATA_WIDTH, OP_WIDTH, SEL_WIDTH)
) (
    input  logic [CW_WIDTH-1:0]       i_cw,
    input  logic                      i_valid,
    output logic                      o_pc_inc,
    output logic [OP_WIDTH-1:0]       o_op,
    output logic [DATA_WIDTH-1:0]     o_a_altern,
    output logic [DATA_WIDTH-1:0]     o_b_altern,
    output logic [SEL_WIDTH-1:0]      o_a_select,
    output logic [SEL_WIDTH-1:0]      o_b_select,
    output logic                      o_a_source,
    output logic                      o_b_source,
    output logic [SEL_WIDTH-1:0]      o_out_select,
    output logic [LOAD_SRC_WIDTH-1:0] o_load_src,
    output logic                      o_store_to_mem,
    output logic                      o_store_to_stk
);

    localparam int unsigned OFF_B_SOURCE = off_b_source(SEL_WIDTH);
    localparam int unsigned OFF_A_SOURCE = off_a_source(SEL_WIDTH);
    localparam int unsigned OFF_B_SELECT = off_b_select(SEL_WIDTH);
    localparam int unsigned OFF_A_SELECT = off_a_select(SEL_WIDTH);
    localparam int unsigned OFF_B_ALTERN = off_b_altern(SEL_WIDTH);
    localparam int unsigned OFF_A_ALTERN = off_a_altern(DATA_WIDTH, SEL_WIDTH);
    localparam int unsigned OFF_OP       = off_op(DATA_WIDTH, SEL_WIDTH);
    localparam int unsigned OFF_PC_INC   = off_pc_inc(DATA_WIDTH, OP_WIDTH, SEL_WIDTH);

    always_comb begin
        o_pc_inc       = 1'b0;
        o_op           = '0;
        o_a_altern     = '0;
        o_b_altern     = '0;
        o_a_select     = '0;
        o_b_select     = '0;
        o_a_source     = 1'b0;
        o_b_source     = 1'b0;
        o_out_select   = '0;
        o_load_src     = '0;
        o_store_to_mem = 1'b0;
        o_store_to_stk = 1'b0;
        if (i_valid) begin
            o_pc_inc       = i_cw[OFF_PC_INC];
            o_op           = i_cw[OFF_OP       +: OP_WIDTH];
            o_a_altern     = i_cw[OFF_A_ALTERN +: DATA_WIDTH];
            o_b_altern     = i_cw[OFF_B_ALTERN +: DATA_WIDTH];
            o_a_select     = i_cw[OFF_A_SELECT +: SEL_WIDTH];
            o_b_select     = i_cw[OFF_B_SELECT +: SEL_WIDTH];
            o_a_source     = i_cw[OFF_A_SOURCE];
            o_b_source     = i_cw[OFF_B_SOURCE];
            o_out_select   = i_cw[OFF_OUT_SELECT +: SEL_WIDTH];
            o_load_src     = i_cw[OFF_LOAD_SRC   +: LOAD_SRC_WIDTH];
            o_store_to_mem = i_cw[OFF_STORE_TO_MEM];
            o_store_to_stk = i_cw[OFF_STORE_TO_STK];
        end
    end

endmodule

// File: rtl/alu_cw_issue_queue.sv
// DEPTH-entry FIFO of packed ALU control words, issued head-first over valid/ready.
// The head entry is split into datapath fields; flush empties the queue at the next edge.
module alu_cw_issue_queue
    import alu_cw_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned OP_WIDTH   = DEF_OP_WIDTH,
    parameter  int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter  int unsigned DEPTH      = 4,
    localparam int unsigned CW_WIDTH   = cw_width(DATA_WIDTH, OP_WIDTH, SEL_WIDTH),
    localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cw_valid,
    output logic                      cw_ready,
    input  logic [CW_WIDTH-1:0]       control_word,
    input  logic                      flush,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [LVL_W-1:0]          level,
    output logic                      program_counter_increment,
    output logic [OP_WIDTH-1:0]       alu_op,
    output logic [DATA_WIDTH-1:0]     alu_a_altern,
    output logic [DATA_WIDTH-1:0]     alu_b_altern,
    output logic [SEL_WIDTH-1:0]      alu_a_select,
    output logic [SEL_WIDTH-1:0]      alu_b_select,
    output logic [SEL_WIDTH-1:0]      alu_out_select,
    output logic                      alu_a_source,
    output logic                      alu_b_source,
    output logic [1:0]                alu_load_src,
    output logic                      alu_store_to_mem,
    output logic                      alu_store_to_stk
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [CW_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;

    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [CW_WIDTH-1:0] w_head;

    // Readiness depends only on registered level and flush, never on issue_ready.
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign cw_ready    = !w_full && !flush;
    assign issue_valid = (r_level != '0);
    assign level       = r_level;

    assign w_push = cw_valid && cw_ready;
    assign w_pop  = issue_valid && issue_ready;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset: unread entries are masked by issue_valid in the split.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= control_word;
        end
    end

    alu_cw_field_split #(
        .DATA_WIDTH (DATA_WIDTH),
        .OP_WIDTH   (OP_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_field_split (
        .i_cw           (w_head),
        .i_valid        (issue_valid),
        .o_pc_inc       (program_counter_increment),
        .o_op           (alu_op),
        .o_a_altern     (alu_a_altern),
        .o_b_altern     (alu_b_altern),
        .o_a_select     (alu_a_select),
        .o_b_select     (alu_b_select),
        .o_a_source     (alu_a_source),
        .o_b_source     (alu_b_source),
        .o_out_select   (alu_out_select),
        .o_load_src     (alu_load_src),
        .o_store_to_mem (alu_store_to_mem),
        .o_store_to_stk (alu_store_to_stk)
    );

endmodule
